// File: rtl/upsample_2x.sv
// 2x nearest-neighbour upsampler for 2-bit signed ternary pixels.
// One input line is buffered, then emitted as two identical lines, each pixel doubled.
//
// state | meaning
// ------+-----------------------------------------------------------
// FILL  | o_rdy=1, capture IN_W input pixels into the line buffer
// EMIT0 | emit first output line (2*IN_W pixels), input ignored
// EMIT1 | emit second, identical output line, then return to FILL
module upsample_2x #(
    parameter int IN_W = 12
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] i_d,
    input  logic       i_v,
    output logic       o_rdy,
    output logic [1:0] o_d,
    output logic       o_v,
    output logic       o_eol
);

    localparam int WW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW = WW + 1;
    localparam logic [WW-1:0] W_LAST = WW'(IN_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(2 * IN_W - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        EMIT0 = 2'd1,
        EMIT1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic [1:0]      od_q, od_d;
    logic            ov_q, ov_d;
    logic            eol_q, eol_d;
    logic            line_we;
    logic [1:0]      line_q [IN_W];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= FILL;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            od_q    <= 2'b00;
            ov_q    <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            od_q    <= od_d;
            ov_q    <= ov_d;
            eol_q   <= eol_d;
        end
    end

    // Line buffer has no reset; stale contents are always overwritten before use.
    always_ff @(posedge clk) begin
        if (line_we) begin
            line_q[wcnt_q] <= i_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        od_d    = od_q;
        ov_d    = 1'b0;
        eol_d   = 1'b0;
        line_we = 1'b0;
        case (state_q)
            FILL: begin
                if (i_v) begin
                    line_we = 1'b1;
                    if (wcnt_q == W_LAST) begin
                        state_d = EMIT0;
                        wcnt_d  = '0;
                        rcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            EMIT0, EMIT1: begin
                // rcnt>>1 repeats each buffered pixel on two consecutive outputs
                od_d = line_q[rcnt_q[RW-1:1]];
                ov_d = 1'b1;
                if (rcnt_q == R_LAST) begin
                    eol_d   = 1'b1;
                    rcnt_d  = '0;
                    state_d = (state_q == EMIT0) ? EMIT1 : FILL;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign o_rdy = (state_q == FILL);
    assign o_d   = od_q;
    assign o_v   = ov_q;
    assign o_eol = eol_q;

endmodule

// File: tb/tb_upsample_2x.sv
// Self-checking bench for upsample_2x: directed scenarios with random pixel data,
// compared against a line-level reference model of the expected output stream.
module tb_upsample_2x;

    localparam int N = 12;

    typedef logic [1:0] line_t [N];
    typedef struct {
        logic [1:0] d;
        logic       eol;
        int         cyc;
    } out_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] i_d;
    logic       i_v;
    logic       o_rdy;
    logic [1:0] o_d;
    logic       o_v;
    logic       o_eol;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [1:0] mon_d [$];
    logic       mon_e [$];
    int         mon_c [$];
    out_t       exp_q [$];

    upsample_2x #(.IN_W(N)) dut (
        .clk   (clk),
        .resetn(resetn),
        .i_d   (i_d),
        .i_v   (i_v),
        .o_rdy (o_rdy),
        .o_d   (o_d),
        .o_v   (o_v),
        .o_eol (o_eol)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn && o_v) begin
            mon_d.push_back(o_d);
            mon_e.push_back(o_eol);
            mon_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: line accepted at cycle k appears twice, each pixel doubled,
    // on cycles k+1 .. k+4N, with eol on the last pixel of each output line.
    task automatic build_exp(input line_t px, input int k);
        out_t o;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 2 * N; j++) begin
                o.d   = px[j / 2];
                o.eol = (j == 2 * N - 1);
                o.cyc = k + 1 + r * 2 * N + j;
                exp_q.push_back(o);
            end
        end
    endtask

    // Called at a negedge; returns the cycle number of the edge accepting the last pixel.
    task automatic feed_line(input string tag, input line_t px, input int gap, output int last_cyc);
        int b;
        for (int i = 0; i < N; i++) begin
            b = 0;
            while (!o_rdy && b < 1000) begin
                @(negedge clk);
                b++;
            end
            chk({tag, "_rdy_before_accept"}, o_rdy, 1);
            i_v = 1'b1;
            i_d = px[i];
            @(negedge clk);
            last_cyc = cyc;
            i_v = 1'b0;
            for (int g = 0; g < gap; g++) @(negedge clk);
        end
    endtask

    task automatic check_outputs(input string tag);
        int b = 0;
        int n;
        while (mon_d.size() < exp_q.size() && b < 20 * N + 200) begin
            @(negedge clk);
            b++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_count"}, mon_d.size(), exp_q.size());
        n = (mon_d.size() < exp_q.size()) ? mon_d.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_d[%0d]", tag, i), mon_d[i], exp_q[i].d);
            chk($sformatf("%s_eol[%0d]", tag, i), mon_e[i], exp_q[i].eol);
            chk($sformatf("%s_cyc[%0d]", tag, i), mon_c[i], exp_q[i].cyc);
        end
        mon_d.delete();
        mon_e.delete();
        mon_c.delete();
        exp_q.delete();
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < N; i++) l[i] = 2'($urandom_range(0, 3));
        return l;
    endfunction

    initial begin
        line_t la, lb;
        int ka, kb, junk, b;

        resetn = 1'b0;
        i_v    = 1'b0;
        i_d    = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_o_v", o_v, 0);
        chk("reset_o_eol", o_eol, 0);
        chk("reset_o_d", o_d, 0);
        chk("reset_o_rdy", o_rdy, 1);
        resetn = 1'b1;
        @(negedge clk);

        // Directed line [1,0,-1,1,1,0,0,-1,-1,1,0,1], back-to-back then every third cycle
        la = '{2'b01, 2'b00, 2'b11, 2'b01, 2'b01, 2'b00,
               2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 2'b01};
        feed_line("t_b2b", la, 0, ka);
        build_exp(la, ka);
        check_outputs("t_b2b");

        feed_line("t_gap", la, 2, ka);
        build_exp(la, ka);
        check_outputs("t_gap");

        // Junk on i_d with i_v high during emission, then line B fed as soon as o_rdy=1
        la = rand_line();
        lb = rand_line();
        feed_line("t_hold_a", la, 0, ka);
        junk = 0;
        while (!o_rdy && junk < 1000) begin
            i_v = 1'b1;
            i_d = 2'($urandom_range(0, 3));
            @(negedge clk);
            junk++;
        end
        chk("t_hold_rdy_low_cycles", junk, 4 * N);
        feed_line("t_hold_b", lb, 0, kb);
        chk("t_hold_b_last_accept", kb, ka + 5 * N);
        build_exp(la, ka);
        build_exp(lb, kb);
        check_outputs("t_hold");

        // Reset during EMIT0 after the 10th output
        la = rand_line();
        feed_line("t_rst", la, 0, ka);
        b = 0;
        while (mon_d.size() < 10 && b < 1000) begin
            @(negedge clk);
            #1;
            b++;
        end
        chk("t_rst_outputs_before", mon_d.size(), 10);
        resetn = 1'b0;
        #1;
        chk("t_rst_o_v", o_v, 0);
        chk("t_rst_o_eol", o_eol, 0);
        chk("t_rst_o_d", o_d, 0);
        mon_d.delete();
        mon_e.delete();
        mon_c.delete();
        @(negedge clk);
        resetn = 1'b1;
        repeat (4 * N + 10) @(negedge clk);
        chk("t_rst_no_outputs", mon_d.size(), 0);
        chk("t_rst_rdy", o_rdy, 1);
        la = rand_line();
        feed_line("t_rst_fresh", la, 0, ka);
        build_exp(la, ka);
        check_outputs("t_rst_fresh");

        // All -1 and all 2'b10 lines pass through unchanged
        for (int i = 0; i < N; i++) la[i] = 2'b11;
        feed_line("t_all11", la, 0, ka);
        build_exp(la, ka);
        check_outputs("t_all11");
        for (int i = 0; i < N; i++) la[i] = 2'b10;
        feed_line("t_all10", la, 1, ka);
        build_exp(la, ka);
        check_outputs("t_all10");

        // Random lines with random input gaps
        for (int t = 0; t < 3; t++) begin
            la = rand_line();
            feed_line("t_rand", la, int'($urandom_range(0, 3)), ka);
            build_exp(la, ka);
            check_outputs($sformatf("t_rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/upsample_2x.md
UPSAMPLE_2X -- requirements
Module: upsample_2x

Interface
REQ-001 Parameter IN_W, default 12: input pixels per line; each output line is 2*IN_W pixels.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 i_d  input  2  signed ternary input pixel (-1, 0, +1); any 2-bit value passes through unchanged.
REQ-005 i_v  input  1  input pixel valid.
REQ-006 o_rdy  output  1  block accepts input this cycle; decoded from state, combinational.
REQ-007 o_d  output  2  signed output pixel, registered.
REQ-008 o_v  output  1  output pixel valid, registered.
REQ-009 o_eol  output  1  registered; high with the last pixel of each output line.

Function
REQ-010 Block SHALL perform 2x nearest-neighbour upsampling: each input line of IN_W pixels becomes 2 output lines of 2*IN_W pixels, each input pixel repeated twice horizontally.
REQ-011 Storage SHALL be an IN_W-entry x 2-bit line buffer, a write counter wcnt (0..IN_W-1) and a read counter rcnt (0..2*IN_W-1).
REQ-012 FSM SHALL have three states: FILL, EMIT0, EMIT1.
REQ-013 o_rdy SHALL be 1 only in FILL.
REQ-014 In FILL, on an edge with i_v=1: buf[wcnt] <= i_d and wcnt increments; if wcnt==IN_W-1, next state is EMIT0, wcnt <= 0, rcnt <= 0.
REQ-015 In FILL, on an edge with i_v=0: no state change, no capture.
REQ-016 When o_rdy=0, i_v SHALL be ignored and no data captured; upstream holds data until o_rdy=1.
REQ-017 In EMIT0/EMIT1, on every edge: o_d <= buf[rcnt>>1], o_v <= 1, rcnt increments.
REQ-018 In EMIT0/EMIT1, on the edge where rcnt==2*IN_W-1: o_eol <= 1 and rcnt <= 0.
REQ-019 On that rcnt==2*IN_W-1 edge, EMIT0 SHALL go to EMIT1 and EMIT1 SHALL go to FILL.
REQ-020 On every other edge, o_eol <= 0.
REQ-021 In FILL, each edge SHALL set o_v <= 0 and o_eol <= 0; o_d holds its last value.
REQ-022 Latency: if edge k accepts the last input pixel of a line, o_v SHALL be high after edges k+1 through k+4*IN_W inclusive, with no gaps.
REQ-023 o_rdy SHALL be 1 in the cycle after edge k+4*IN_W.
REQ-024 If i_v=1 in that first FILL cycle, the pixel SHALL be captured as wcnt=0 of the next line.
REQ-025 Output lines 0 and 1 of a pair SHALL be identical.
REQ-026 Arithmetic: counters only; pixel values are never modified; sign encoding is preserved (2'b11 = -1, 2'b01 = +1, 2'b00 = 0).
REQ-027 Throughput: one input line per IN_W + 4*IN_W cycles at best; there is no output backpressure.

Reset
REQ-028 On resetn=0, asynchronously: state = FILL, wcnt = 0, rcnt = 0, o_d = 0, o_v = 0, o_eol = 0.
REQ-029 Line-buffer contents are not reset.
REQ-030 Reset mid-FILL or mid-EMIT SHALL discard the partial line and pending outputs; o_v drops immediately and does not resume.
REQ-031 After resetn rises, o_rdy SHALL be 1 and the next accepted pixel is wcnt=0.

Verification
REQ-032 Reset, then 12 back-to-back pixels [1,0,-1,1,1,0,0,-1,-1,1,0,1] -> 48 contiguous o_v outputs.
  - Output line: 1,1,0,0,-1,-1,1,1,... sent twice.
  - o_eol on outputs 24 and 48.
  - First o_v after the edge following the last accept.
REQ-033 Same 12 pixels with i_v high every third cycle -> identical 48-pixel output; o_rdy stays 1 until the 12th accept.
REQ-034 i_v held high with a changing i_d during EMIT0/EMIT1 -> o_rdy=0 and buffer unchanged (outputs match the captured line); the first pixel after return to FILL is captured at wcnt=0.
REQ-035 resetn pulsed low after the 10th output of EMIT0 -> o_v=0, o_eol=0, o_d=0 immediately.
  - No further outputs.
  - A fresh 12-pixel line afterwards gives a clean 48 outputs.
REQ-036 Line of all 2'b11 -> 48 outputs all 2'b11; line of all 2'b10 -> passed through unchanged.
REQ-037 Two consecutive lines A then B, each fed as soon as o_rdy=1 -> 96 outputs: A, A, B, B; o_eol count 4; o_v low exactly during B's fill cycles.
